// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
//   DEPTH-entry FIFO between instruction fetch and decode. Each entry holds
//   {pc, pc_4, instruction}. Valid/ready handshake on both sides, synchronous
//   flush for branch/jump redirect, and a NOP bubble presented when empty.
//
//   Optional feature macro: IFQ_BYPASS_EN
//     When defined, an empty queue forwards the incoming tuple to the output
//     combinationally in the same cycle. A tuple that decode takes in that
//     cycle is never written to storage.
//     When undefined, there is no input-to-output combinational path, and a
//     pushed tuple appears one cycle later.
// ---------------------------------------------------------------------------
module if_fetch_queue #(
  parameter int                XLEN  = 32,
  parameter int                DEPTH = 4,
  parameter logic [XLEN-1:0]   NOP   = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [XLEN-1:0]            in_pc_4,
  input  logic [XLEN-1:0]            in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_pc_4,
  output logic [XLEN-1:0]            out_instr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [CW-1:0] C_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [AW-1:0] P_ZERO  = {AW{1'b0}};
  localparam logic [AW-1:0] P_ONE   = AW'(1);

  // Storage (deliberately not reset: contents are meaningless while count==0)
  logic [XLEN-1:0] r_mem_pc    [DEPTH];
  logic [XLEN-1:0] r_mem_pc_4  [DEPTH];
  logic [XLEN-1:0] r_mem_instr [DEPTH];

  // Control state
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Combinational control
  logic w_empty;
  logic w_full;
  logic w_bypass;
  logic w_out_valid;
  logic w_push;
  logic w_pop;
  logic w_through;
  logic w_wr_en;
  logic w_rd_en;

  // Occupancy flags, bypass qualification and handshake decode
  always_comb begin
    w_empty     = (r_count == C_ZERO);
    w_full      = (r_count == C_DEPTH);
`ifdef IFQ_BYPASS_EN
    // Forward only into an empty queue and never while redirecting
    w_bypass    = w_empty & in_valid & ~flush;
    w_out_valid = ~flush & (~w_empty | w_bypass);
`else
    w_bypass    = 1'b0;
    w_out_valid = ~w_empty;
`endif
    // in_ready depends on occupancy only, so a full queue refuses input
    // even when decode frees a slot in the same cycle
    w_push      = in_valid & ~w_full;
    w_pop       = w_out_valid & out_ready;
    // A forwarded tuple consumed immediately never touches storage
    w_through   = w_bypass & out_ready;
    // Flush discards any push or pop in the same cycle
    w_wr_en     = w_push & ~w_through & ~flush;
    w_rd_en     = w_pop  & ~w_through & ~flush;
  end

  // Occupancy counter: +1 on write only, -1 on read only, else hold
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= C_ZERO;
    end else if (flush) begin
      r_count <= C_ZERO;
    end else begin
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Write/read pointers; DEPTH is a power of two so they wrap naturally
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= P_ZERO;
      r_rd_ptr <= P_ZERO;
    end else if (flush) begin
      r_wr_ptr <= P_ZERO;
      r_rd_ptr <= P_ZERO;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + P_ONE;
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + P_ONE;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
    end
  end

  // Tuple storage written at the tail on an accepted push
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem_pc[r_wr_ptr]    <= in_pc;
      r_mem_pc_4[r_wr_ptr]  <= in_pc_4;
      r_mem_instr[r_wr_ptr] <= in_instr;
    end
  end

  // Output selection: head entry, forwarded input, or the empty NOP bubble
  always_comb begin
    out_pc    = {XLEN{1'b0}};
    out_pc_4  = {XLEN{1'b0}};
    out_instr = NOP;
    if (w_out_valid) begin
      if (w_bypass) begin
        out_pc    = in_pc;
        out_pc_4  = in_pc_4;
        out_instr = in_instr;
      end else begin
        out_pc    = r_mem_pc[r_rd_ptr];
        out_pc_4  = r_mem_pc_4[r_rd_ptr];
        out_instr = r_mem_instr[r_rd_ptr];
      end
    end else begin
      out_pc    = {XLEN{1'b0}};
      out_pc_4  = {XLEN{1'b0}};
      out_instr = NOP;
    end
  end

  // Handshake and occupancy outputs
  always_comb begin
    out_valid = w_out_valid;
    in_ready  = ~w_full;
    count     = r_count;
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue (DEPTH=4, XLEN=32).
// Reference model: a queue of tuples updated by the handshake rules.
module tb_if_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h00000013;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_pc = 32'd0;
  logic [31:0] in_pc_4 = 32'd0;
  logic [31:0] in_instr = 32'd0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_pc_4;
  logic [31:0] out_instr;
  logic [2:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } ent_t;

  ent_t q[$];

  logic        exp_valid;
  logic        exp_ready;
  logic [2:0]  exp_count;
  logic [31:0] exp_pc;
  logic [31:0] exp_pc4;
  logic [31:0] exp_instr;

  if_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_pc_4(in_pc_4), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pc_4(out_pc_4), .out_instr(out_instr),
    .count(count)
  );

  always #5 clk = ~clk;

  // Expected outputs from the model queue and the current inputs
  function automatic void calc_exp();
    bit bypass;
    bypass = BYP && (q.size() == 0) && in_valid && !flush;
    if (BYP) exp_valid = !flush && ((q.size() != 0) || bypass);
    else     exp_valid = (q.size() != 0);
    if (!exp_valid) begin
      exp_pc = 32'd0; exp_pc4 = 32'd0; exp_instr = NOP;
    end else if (q.size() != 0) begin
      exp_pc = q[0].pc; exp_pc4 = q[0].pc4; exp_instr = q[0].instr;
    end else begin
      exp_pc = in_pc; exp_pc4 = in_pc_4; exp_instr = in_instr;
    end
    exp_count = 3'(q.size());
    exp_ready = (q.size() != DEPTH);
  endfunction

  // Model state change at a rising edge
  function automatic void model_edge();
    bit push, pop, thru;
    calc_exp();
    if (flush) begin
      q.delete();
    end else begin
      push = in_valid && (q.size() < DEPTH);
      pop  = exp_valid && out_ready;
      thru = pop && (q.size() == 0);
      if (pop && !thru) void'(q.pop_front());
      if (push && !thru) q.push_back('{pc: in_pc, pc4: in_pc_4, instr: in_instr});
    end
  endfunction

  task automatic set_in(input bit v, input bit rdy, input bit fl,
                        input logic [31:0] pc, input logic [31:0] instr);
    in_valid  = v;
    out_ready = rdy;
    flush     = fl;
    in_pc     = pc;
    in_pc_4   = pc + 32'd4;
    in_instr  = instr;
    #1;
    calc_exp();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    set_in(0, 0, 0, 32'd0, 32'd0);
    n_checks++;
    if ({out_valid, in_ready, count, out_pc, out_pc_4, out_instr} !== {1'b0, 1'b1, 3'd0, 32'd0, 32'd0, NOP}) begin
      n_errors++;
      $display("FAIL reset_init: got v=%0b rdy=%0b cnt=%0d pc=%h pc4=%h ins=%h want v=0 rdy=1 cnt=0 pc=0 pc4=0 ins=%h",
               out_valid, in_ready, count, out_pc, out_pc_4, out_instr, NOP);
    end
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 0, 32'h40 + 32'(4 * i), $urandom);
      tick();
    end
    set_in(0, 0, 0, 32'd0, 32'd0);
    n_checks++;
    if (count !== 3'd3) begin
      n_errors++;
      $display("FAIL reset_fill3: count got %0d want 3", count);
    end
    #2 reset_n = 1'b0;
    #1;
    q.delete();
    n_checks++;
    if ({out_valid, in_ready, count, out_instr} !== {1'b0, 1'b1, 3'd0, NOP}) begin
      n_errors++;
      $display("FAIL reset_async: got v=%0b rdy=%0b cnt=%0d ins=%h want v=0 rdy=1 cnt=0 ins=%h",
               out_valid, in_ready, count, out_instr, NOP);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      set_in(1, 0, 0, 32'h100 + 32'(4 * i), $urandom);
      tick();
    end
    set_in(1, 0, 0, 32'h110, 32'hDEADBEEF);
    n_checks++;
    if ({count, in_ready} !== {3'd4, 1'b0}) begin
      n_errors++;
      $display("FAIL fill_full: got cnt=%0d rdy=%0b want cnt=4 rdy=0", count, in_ready);
    end
    tick();
    set_in(0, 0, 0, 32'd0, 32'd0);
    n_checks++;
    if (count !== 3'd4) begin
      n_errors++;
      $display("FAIL fill_5th_rejected: count got %0d want 4", count);
    end
    for (int i = 0; i < 4; i++) begin
      set_in(0, 1, 0, 32'd0, 32'd0);
      n_checks++;
      if ({out_valid, out_pc, out_pc_4, out_instr} !== {1'b1, 32'h100 + 32'(4 * i), 32'h104 + 32'(4 * i), exp_instr}) begin
        n_errors++;
        $display("FAIL fill_drain%0d: got v=%0b pc=%h pc4=%h ins=%h want v=1 pc=%h pc4=%h ins=%h", i,
                 out_valid, out_pc, out_pc_4, out_instr, 32'h100 + 32'(4 * i), 32'h104 + 32'(4 * i), exp_instr);
      end
      tick();
    end
    set_in(0, 0, 0, 32'd0, 32'd0);
    n_checks++;
    if ({out_valid, count, out_instr} !== {1'b0, 3'd0, NOP}) begin
      n_errors++;
      $display("FAIL fill_empty: got v=%0b cnt=%0d ins=%h want v=0 cnt=0 ins=%h", out_valid, count, out_instr, NOP);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] prev;
    logic [31:0] pc;
    prev = 32'h200;
    set_in(1, 0, 0, prev, $urandom);
    tick();
    for (int i = 1; i <= 10; i++) begin
      pc = 32'h200 + 32'(4 * i);
      set_in(1, 1, 0, pc, $urandom);
      n_checks++;
      if ({count, out_valid, out_pc} !== {3'd1, 1'b1, prev}) begin
        n_errors++;
        $display("FAIL wrap%0d: got cnt=%0d v=%0b pc=%h want cnt=1 v=1 pc=%h", i, count, out_valid, out_pc, prev);
      end
      tick();
      prev = pc;
    end
    set_in(0, 1, 0, 32'd0, 32'd0);
    tick();
  endtask

  task automatic test_back_to_back();
    set_in(1, 0, 0, 32'h300, 32'h11111111); tick();
    set_in(1, 0, 0, 32'h304, 32'h22222222); tick();
    set_in(1, 1, 0, 32'h308, 32'h33333333); tick();
    set_in(0, 0, 0, 32'd0, 32'd0);
    n_checks++;
    if ({count, out_pc, out_instr} !== {3'd2, 32'h304, 32'h22222222}) begin
      n_errors++;
      $display("FAIL simul_head: got cnt=%0d pc=%h ins=%h want cnt=2 pc=304 ins=22222222", count, out_pc, out_instr);
    end
    set_in(0, 1, 0, 32'd0, 32'd0); tick();
    set_in(0, 1, 0, 32'd0, 32'd0);
    n_checks++;
    if ({out_valid, out_pc, out_pc_4, out_instr} !== {1'b1, 32'h308, 32'h30C, 32'h33333333}) begin
      n_errors++;
      $display("FAIL simul_tail: got v=%0b pc=%h pc4=%h ins=%h want v=1 pc=308 pc4=30c ins=33333333",
               out_valid, out_pc, out_pc_4, out_instr);
    end
    tick();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 0, 32'h400 + 32'(4 * i), $urandom);
      tick();
    end
    set_in(1, 1, 1, 32'h40C, 32'h44444444);
    n_checks++;
    if (out_valid !== exp_valid) begin
      n_errors++;
      $display("FAIL flush_cycle_valid: got %0b want %0b", out_valid, exp_valid);
    end
    tick();
    set_in(0, 0, 0, 32'd0, 32'd0);
    n_checks++;
    if ({count, out_valid, out_instr, in_ready} !== {3'd0, 1'b0, NOP, 1'b1}) begin
      n_errors++;
      $display("FAIL flush_after: got cnt=%0d v=%0b ins=%h rdy=%0b want cnt=0 v=0 ins=%h rdy=1",
               count, out_valid, out_instr, in_ready, NOP);
    end
    set_in(0, 0, 1, 32'd0, 32'd0); tick();
    set_in(0, 0, 0, 32'd0, 32'd0);
    n_checks++;
    if ({count, out_valid} !== {3'd0, 1'b0}) begin
      n_errors++;
      $display("FAIL flush_empty: got cnt=%0d v=%0b want cnt=0 v=0", count, out_valid);
    end
  endtask

  task automatic test_bypass();
    set_in(1, 1, 0, 32'h500, 32'h00A00093);
    n_checks++;
    if ({out_valid, out_instr} !== (BYP ? {1'b1, 32'h00A00093} : {1'b0, NOP})) begin
      n_errors++;
      $display("FAIL bypass_same_cycle: got v=%0b ins=%h (bypass=%0b)", out_valid, out_instr, BYP);
    end
    tick();
    set_in(0, 1, 0, 32'd0, 32'd0);
    n_checks++;
    if ({out_valid, out_instr, count} !== (BYP ? {1'b0, NOP, 3'd0} : {1'b1, 32'h00A00093, 3'd1})) begin
      n_errors++;
      $display("FAIL bypass_next_cycle: got v=%0b ins=%h cnt=%0d (bypass=%0b)", out_valid, out_instr, count, BYP);
    end
    tick();
    set_in(0, 0, 0, 32'd0, 32'd0);
    n_checks++;
    if (count !== 3'd0) begin
      n_errors++;
      $display("FAIL bypass_drained: count got %0d want 0", count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 20) == 0, $urandom, $urandom);
      n_checks++;
      if ({out_valid, in_ready, count, out_pc, out_pc_4, out_instr} !==
          {exp_valid, exp_ready, exp_count, exp_pc, exp_pc4, exp_instr}) begin
        n_errors++;
        $display("FAIL rnd%0d: got v=%0b rdy=%0b cnt=%0d pc=%h pc4=%h ins=%h want v=%0b rdy=%0b cnt=%0d pc=%h pc4=%h ins=%h",
                 i, out_valid, in_ready, count, out_pc, out_pc_4, out_instr,
                 exp_valid, exp_ready, exp_count, exp_pc, exp_pc4, exp_instr);
      end
      tick();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_fill();
    test_wrap();
    test_back_to_back();
    test_flush();
    test_bypass();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
